uart_tx_feeder: RTL
===================

// Module: uart_tx_feeder
// PURPOSE
//  Byte FIFO plus launch sequencer sitting directly upstream of the UART transmitter.
//  Host logic pushes bytes at any rate; the block drains them one at a time into the transmitter.
//  Transmitter handshake: xmitH/xmit_dataH out, xmit_doneH in (high while idle, low while busy).
//  Each byte is removed from the FIFO only once the transmitter is seen busy, so no byte is lost.
// PARAMETERS
//  DEPTH         16  FIFO entries; power of two, >=2
//  BUSY_TIMEOUT   4  cycles to wait for xmit_doneH to fall after a launch before retrying
// PORTS
//  sys_clk     in   1           system clock; all logic on posedge
//  sys_rst_l   in   1           reset, synchronous, active-low
//  wr_en       in   1           push wr_data this cycle
//  wr_data     in   8           byte to queue
//  full        out  1           FIFO holds DEPTH entries
//  empty       out  1           FIFO holds 0 entries
//  level       out  $clog2(DEPTH)+1  current occupancy
//  overflowH   out  1           sticky: a push was dropped
//  clr_ovf     in   1           clears overflowH (a drop in the same cycle wins)
//  xmitH       out  1           one-cycle launch strobe to transmitter
//  xmit_dataH  out  8           byte to transmit; held stable from launch until the next launch
//  xmit_doneH  in   1           transmitter idle/done indication
//  busy        out  1           sequencer not in IDLE
// BEHAVIOUR
//  Reset (sys_rst_l==0 at posedge): pointers/level=0, empty=1, full=0, overflowH=0, xmitH=0,
//   xmit_dataH=8'h00, state=IDLE, timeout counter=0. Applies mid-frame too; any in-flight byte is discarded.
//  FIFO: circular buffer, rd/wr pointers wrap modulo DEPTH; level is an explicit counter.
//   Push accepted if !full, or if full and a pop happens in the same cycle.
//   Push while full with no pop: byte dropped, overflowH<=1, level unchanged.
//   Push+pop in same cycle: level unchanged. Pop only ever occurs on WAIT_BUSY->WAIT_DONE.
//   Push into an empty FIFO becomes visible to the sequencer the next cycle (no fall-through).
//  Sequencer states (encoding in package):
//   IDLE:      if !empty && xmit_doneH -> LAUNCH; xmit_dataH<=mem[rd_ptr] on this transition.
//   LAUNCH:    xmitH=1 for exactly this cycle; timeout counter<=0 -> WAIT_BUSY.
//   WAIT_BUSY: if !xmit_doneH -> pop head, -> WAIT_DONE.
//              else if counter==BUSY_TIMEOUT-1 -> IDLE (head not popped; byte relaunched).
//              else counter++.
//   WAIT_DONE: if xmit_doneH -> IDLE.
//  Outputs xmitH and busy are registered (derived from the next state); min launch-to-launch spacing
//   is bounded by the transmitter frame, not by this block.
//  Illegal state encoding -> IDLE with xmitH=0.
//  clr_ovf and the overflow event in the same cycle: overflowH stays 1.
// STRUCTURE
//  Package uart_pkg: typedef enum feeder_state_t {IDLE,LAUNCH,WAIT_BUSY,WAIT_DONE};
//   localparam UART_DATA_W=8.
//  Sub-module sync_fifo (DATA_W, DEPTH; push/pop/full/empty/level/dout) instantiated once;
//   sequencer, overflow flag and timeout counter live in the top.
// TESTING
//  1 Reset: hold sys_rst_l=0 for 3 cycles -> empty=1, level=0, xmitH=0, busy=0, overflowH=0.
//  2 Single byte: push 8'hA5 with transmitter model idle -> one xmitH pulse, xmit_dataH=8'hA5,
//    level back to 0 once xmit_doneH falls.
//  3 Burst: push 8'h01..8'h05 back-to-back -> five launches in order 01..05, each only after
//    xmit_doneH returns high; level peaks at 5 (or 4 if the first byte has already been popped).
//  4 Overflow: DEPTH=16, transmitter held busy, push 17 bytes -> full=1, 17th dropped, overflowH=1;
//    clr_ovf -> overflowH=0; drained data equals the first 16 bytes.
//  5 Timeout: xmit_doneH stuck high, one byte 8'h3C -> xmitH repeats every BUSY_TIMEOUT+2 cycles,
//    level stays 1; release model -> popped once, no duplicate.
//  6 Reset mid-operation: sys_rst_l=0 during WAIT_DONE with 3 queued -> next cycle level=0,
//    busy=0, no further xmitH.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit feeder: sequencer state encoding and byte width.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Single-clock circular-buffer FIFO with an explicit occupancy counter and registered head.
module sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int LW     = AW + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [LW-1:0]     level_o,
    output logic [DATA_W-1:0] dout_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign do_pop  = pop_i && (level_q != '0);
    assign do_push = push_i && ((level_q != LW'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch sequencer feeding a UART transmitter; a byte is popped only once
// the transmitter has been seen busy, otherwise it is relaunched after a timeout.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter  int DEPTH        = 16,
    parameter  int BUSY_TIMEOUT = 4,
    localparam int LW           = $clog2(DEPTH) + 1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_l,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [LW-1:0]          level,
    output logic                   overflowH,
    input  logic                   clr_ovf,
    output logic                   xmitH,
    output logic [UART_DATA_W-1:0] xmit_dataH,
    input  logic                   xmit_doneH,
    output logic                   busy
);

    localparam int CW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    feeder_state_t          state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   xmit_q;
    logic                   busy_q;
    logic                   ovf_q, ovf_d;
    logic                   pop;
    logic                   drop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_dout;

    sync_fifo #(
        .DATA_W (UART_DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_l),
        .push_i  (wr_en),
        .din_i   (wr_data),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level),
        .dout_o  (fifo_dout)
    );

    assign drop = wr_en && fifo_full && !pop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && xmit_doneH) begin
                    state_d = LAUNCH;
                    data_d  = fifo_dout;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!xmit_doneH) begin
                    pop     = 1'b1;
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (xmit_doneH) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_l) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            xmit_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            xmit_q  <= (state_d == LAUNCH);
            busy_q  <= (state_d != IDLE);
            ovf_q   <= ovf_d;
        end
    end

    assign full       = fifo_full;
    assign empty      = fifo_empty;
    assign overflowH  = ovf_q;
    assign xmitH      = xmit_q;
    assign xmit_dataH = data_q;
    assign busy       = busy_q;

endmodule
